grid_mover: RTL

GRID_MOVER -- requirements
Module: grid_mover

---
 rtl/maze_pkg.sv | 32 +++
 rtl/wall_probe.sv | 41 ++++
 rtl/grid_mover.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared maze types: heading encodings, mover FSM states and direction helpers.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECIDE = 2'd1,
    MOVE   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Opposite headings differ only in the MSB of the encoding.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  function automatic dir_e req_to_dir(input logic [3:0] req);
    dir_e d;
    if (req[0])      d = DIR_RIGHT;
    else if (req[1]) d = DIR_DOWN;
    else if (req[2]) d = DIR_LEFT;
    else             d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/wall_probe.sv
// Combinational wall lookup: which of the four neighbours of a cell can be entered.
module wall_probe
  import maze_pkg::*;
#(
  parameter int COLS = 10,
  parameter int ROWS = 15,
  parameter int CXW  = $clog2(COLS),
  parameter int CYW  = $clog2(ROWS)
) (
  input  logic [CXW-1:0]             cell_x,
  input  logic [CYW-1:0]             cell_y,
  input  logic [(ROWS+1)*COLS-1:0]   h_walls,
  input  logic [ROWS*(COLS+1)-1:0]   v_walls,
  output logic [3:0]                 open_dirs
);

  localparam int HIW = $clog2((ROWS+1)*COLS);
  localparam int VIW = $clog2(ROWS*(COLS+1));
  localparam logic [CXW-1:0] LAST_COL = CXW'(COLS-1);
  localparam logic [CYW-1:0] LAST_ROW = CYW'(ROWS-1);

  logic [HIW-1:0] w_h_top;
  logic [HIW-1:0] w_h_bot;
  logic [VIW-1:0] w_v_left;
  logic [VIW-1:0] w_v_right;

  assign w_h_top   = HIW'(32'(cell_y) * COLS + 32'(cell_x));
  assign w_h_bot   = HIW'((32'(cell_y) + 32'd1) * COLS + 32'(cell_x));
  assign w_v_left  = VIW'(32'(cell_y) * (COLS + 1) + 32'(cell_x));
  assign w_v_right = VIW'(32'(cell_y) * (COLS + 1) + 32'(cell_x) + 32'd1);

  // Grid edges are treated as walls even if the wall vectors leave them clear.
  always_comb begin
    open_dirs            = 4'b0000;
    open_dirs[DIR_RIGHT] = !v_walls[w_v_right] && (cell_x < LAST_COL);
    open_dirs[DIR_DOWN]  = !h_walls[w_h_bot]   && (cell_y < LAST_ROW);
    open_dirs[DIR_LEFT]  = !v_walls[w_v_left]  && (cell_x != '0);
    open_dirs[DIR_UP]    = !h_walls[w_h_top]   && (cell_y != '0);
  end

endmodule

// File: rtl/grid_mover.sv
// Pixel-stepping maze mover: turns at cell-aligned positions, reverses anywhere,
// stops against walls and grid edges.
//
//   state  | meaning
//   IDLE   | waiting for a step request
//   DECIDE | resolve pending turn, latch blocked and start cell
//   MOVE   | advance one pixel unless blocked
//   DONE   | done pulse, cell_enter on arrival in a new cell
module grid_mover
  import maze_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 15,
  parameter int CELL_LOG2 = 5,
  parameter int XW        = $clog2(COLS) + CELL_LOG2,
  parameter int YW        = $clog2(ROWS) + CELL_LOG2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 dir_req,
  input  logic                       step,
  input  logic [(ROWS+1)*COLS-1:0]   h_walls,
  input  logic [ROWS*(COLS+1)-1:0]   v_walls,
  output logic [XW-1:0]              pos_x,
  output logic [YW-1:0]              pos_y,
  output logic [1:0]                 direction,
  output logic                       busy,
  output logic                       done,
  output logic                       blocked,
  output logic                       cell_enter
);

  localparam int CXW = XW - CELL_LOG2;
  localparam int CYW = YW - CELL_LOG2;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XW-1:0]   r_pos_x;
  logic [YW-1:0]   r_pos_y;
  dir_e            r_dir;
  dir_e            r_pend;
  logic            r_pend_valid;
  logic            r_blocked;
  logic [CXW-1:0]  r_cell_x;
  logic [CYW-1:0]  r_cell_y;

  logic [CXW-1:0]  w_cell_x;
  logic [CYW-1:0]  w_cell_y;
  logic            w_aligned;
  logic [3:0]      w_open;
  dir_e            w_dir_nxt;
  logic            w_consume;
  logic            w_blocked_nxt;
  logic            w_busy;
  logic            w_done;
  logic            w_cell_enter;

  assign w_cell_x  = r_pos_x[XW-1:CELL_LOG2];
  assign w_cell_y  = r_pos_y[YW-1:CELL_LOG2];
  assign w_aligned = (r_pos_x[CELL_LOG2-1:0] == '0) && (r_pos_y[CELL_LOG2-1:0] == '0);

  wall_probe #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CXW  (CXW),
    .CYW  (CYW)
  ) u_wall_probe (
    .cell_x    (w_cell_x),
    .cell_y    (w_cell_y),
    .h_walls   (h_walls),
    .v_walls   (v_walls),
    .open_dirs (w_open)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_cell_enter = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (step) w_state_nxt = DECIDE;
      end
      DECIDE: w_state_nxt = MOVE;
      MOVE:   w_state_nxt = DONE;
      DONE: begin
        w_state_nxt  = IDLE;
        w_done       = 1'b1;
        w_cell_enter = w_aligned && ((w_cell_x != r_cell_x) || (w_cell_y != r_cell_y));
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Turns only happen on cell corners; a reversal stays on the same axis, so it is safe mid-cell.
  always_comb begin
    w_dir_nxt = r_dir;
    w_consume = 1'b0;
    if (r_pend_valid) begin
      if (w_aligned) begin
        w_consume = 1'b1;
        if (w_open[r_pend]) w_dir_nxt = r_pend;
      end else if (r_pend == opposite(r_dir)) begin
        w_consume = 1'b1;
        w_dir_nxt = r_pend;
      end
    end
    w_blocked_nxt = w_aligned && !w_open[w_dir_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_dir        <= DIR_RIGHT;
      r_pend       <= DIR_RIGHT;
      r_pend_valid <= 1'b0;
      r_blocked    <= 1'b0;
      r_cell_x     <= '0;
      r_cell_y     <= '0;
    end else begin
      // A live button press always refreshes the pending request, even while it is being consumed.
      if (dir_req != 4'b0000) begin
        r_pend       <= req_to_dir(dir_req);
        r_pend_valid <= 1'b1;
      end else if ((r_state == DECIDE) && w_consume) begin
        r_pend_valid <= 1'b0;
      end

      if (r_state == DECIDE) begin
        r_dir     <= w_dir_nxt;
        r_blocked <= w_blocked_nxt;
        r_cell_x  <= w_cell_x;
        r_cell_y  <= w_cell_y;
      end

      if ((r_state == MOVE) && !r_blocked) begin
        case (r_dir)
          DIR_RIGHT: r_pos_x <= r_pos_x + XW'(1);
          DIR_DOWN:  r_pos_y <= r_pos_y + YW'(1);
          DIR_LEFT:  r_pos_x <= r_pos_x - XW'(1);
          DIR_UP:    r_pos_y <= r_pos_y - YW'(1);
          default:   r_pos_x <= r_pos_x;
        endcase
      end
    end
  end

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign direction  = r_dir;
  assign busy       = w_busy;
  assign done       = w_done;
  assign blocked    = r_blocked;
  assign cell_enter = w_cell_enter;

endmodule
